// File: rtl/data_sram_responder_pkg.sv
// Shared encodings for the data SRAM responder: access sizes, FSM states,
// wait-counter width and the alignment rule applied to every request.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wide enough for the largest wait count (LATENCY=8 loads 6).
  localparam int CNT_W = 3;

  // True when the access size is illegal or the address is not naturally aligned.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (size_e'(size))
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addrLo[0];
      SIZE_W:  bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Request/response bus between an initiator and the data SRAM responder.
interface data_sram_responder_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata, err, busy
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata, err, busy
  );

endinterface

// File: rtl/data_sram_responder_be_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and
// a one-cycle registered read that holds its value until the next read.
module be_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // Byte-lane write and registered read sharing the single address port.
  // NOTE: the array has no reset so it maps onto SRAM macros and keeps its
  // contents across rst; sequential state uses <= so all flops update together.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: accepts one request at a time, answers after a fixed
// LATENCY with a one-cycle data_ok pulse, flags misaligned/illegal accesses
// and commits byte-masked writes at the end of the response cycle.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input logic                  clk,
  input logic                  rst,
  data_sram_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_e             stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic               accept;
  logic               dataOk;
  logic               wrQ;
  logic               errQ;
  logic [ADDR_W-1:0]  idxQ;
  logic [3:0]         wstrbQ;
  logic [31:0]        wdataQ;
  logic [ADDR_W-1:0]  ramAddr;
  logic               ramWe;
  logic [31:0]        ramRdata;
  logic               unusedAddr;

  // Requests are only taken in IDLE and never while reset is held.
  assign bus.addr_ok = rst & (stateQ == IDLE) & bus.req;
  assign accept      = bus.addr_ok;

  // Next-state and wait-counter logic.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    case (stateQ)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            stateD = RESP;
          end else begin
            stateD = WAIT;
            cntD   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cntQ == '0) stateD = RESP;
        else            cntD   = cntQ - CNT_W'(1);
      end
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Snapshot of the request at acceptance so later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrQ    <= 1'b0;
      errQ   <= 1'b0;
      idxQ   <= '0;
      wstrbQ <= '0;
      wdataQ <= '0;
    end else if (accept) begin
      wrQ    <= bus.wr;
      errQ   <= isMisaligned(bus.size, bus.addr[1:0]);
      idxQ   <= bus.addr[ADDR_W+1:2];
      wstrbQ <= bus.wstrb;
      wdataQ <= bus.wdata;
    end
  end

  // The read is launched straight from the bus at acceptance so data is ready
  // even for LATENCY=1; the write uses the captured index while in RESP, when
  // no new request can be accepted, so the single port never conflicts.
  assign ramAddr    = (stateQ == RESP) ? idxQ : bus.addr[ADDR_W+1:2];
  assign ramWe      = (stateQ == RESP) & wrQ & ~errQ;
  assign unusedAddr = ^bus.addr[31:ADDR_W+2];

  be_ram #(
    .ADDR_W (ADDR_W)
  ) uRam (
    .clk   (clk),
    .re    (accept),
    .we    (ramWe),
    .be    (wstrbQ),
    .addr  (ramAddr),
    .wdata (wdataQ),
    .rdata (ramRdata)
  );

  assign dataOk       = (stateQ == RESP);
  assign bus.data_ok  = dataOk;
  assign bus.busy     = (stateQ != IDLE);
  assign bus.err      = dataOk & errQ;
  assign bus.rdata    = (dataOk & ~wrQ & ~errQ) ? ramRdata : 32'h0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: stimulus pushes expected responses, monitors pop and
// compare on every data_ok. Instance A uses LATENCY=2, instance B LATENCY=1.
module tb_data_sram_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   cyc = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  exp_t qA[$];
  exp_t qB[$];
  exp_t eA;
  exp_t eB;
  int   accB[$];
  logic [31:0] expRdB = 32'h0;

  data_sram_responder_if busA ();
  data_sram_responder_if busB ();

  data_sram_responder #(.LATENCY(LAT_A), .ADDR_W(10)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (busA)
  );

  data_sram_responder #(.LATENCY(LAT_B), .ADDR_W(10)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for instance A.
  always @(negedge clk) begin
    if (busA.data_ok) begin
      if (qA.size() == 0) begin
        check("A unexpected data_ok", 1, 0);
      end else begin
        eA = qA.pop_front();
        check("A rdata", busA.rdata, eA.rdata);
        check("A err", busA.err, eA.err);
        check("A data_ok cycle", cyc, eA.cyc);
      end
    end else begin
      check("A outputs zero without data_ok", {busA.rdata, busA.err}, 0);
    end
    check("A addr_ok while busy", busA.addr_ok & busA.busy, 0);
  end

  // Monitor for instance B; also records acceptances and their expectations.
  always @(negedge clk) begin
    if (busB.data_ok) begin
      if (qB.size() == 0) begin
        check("B unexpected data_ok", 1, 0);
      end else begin
        eB = qB.pop_front();
        check("B rdata", busB.rdata, eB.rdata);
        check("B err", busB.err, eB.err);
        check("B data_ok cycle", cyc, eB.cyc);
      end
    end else begin
      check("B outputs zero without data_ok", {busB.rdata, busB.err}, 0);
    end
    check("B addr_ok while busy", busB.addr_ok & busB.busy, 0);
    if (busB.req && busB.addr_ok) begin
      qB.push_back('{expRdB, 1'b0, cyc + LAT_B});
      accB.push_back(cyc);
    end
  end

  task automatic drainA(input string name);
    int n = 0;
    while (qA.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check({name, " response timeout"}, qA.size(), 0);
  endtask

  task automatic issueA(input string name, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [3:0] strb, input logic [31:0] d,
                        input logic [31:0] expRd, input logic expErr);
    int waited = 0;
    @(posedge clk); #1;
    busA.req = 1'b1; busA.wr = w; busA.size = sz;
    busA.addr = a; busA.wstrb = strb; busA.wdata = d;
    @(negedge clk);
    while (!busA.addr_ok && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, " addr_ok same cycle as req"}, waited, 0);
    if (busA.addr_ok) qA.push_back('{expRd, expErr, cyc + LAT_A});
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the captured request must be unaffected.
    busA.req = 1'b0; busA.wr = ~w; busA.size = ~sz;
    busA.addr = ~a; busA.wstrb = ~strb; busA.wdata = ~d;
    drainA(name);
  endtask

  initial begin
    int n;
    rstA = 1'b1; rstB = 1'b1;
    busA.req = 1'b1; busA.wr = 1'b0; busA.size = 2'd2;
    busA.addr = 32'h0; busA.wstrb = 4'h0; busA.wdata = 32'h0;
    busB.req = 1'b0; busB.wr = 1'b0; busB.size = 2'd2;
    busB.addr = 32'h0; busB.wstrb = 4'h0; busB.wdata = 32'h0;
    #1 rstA = 1'b0; rstB = 1'b0;

    // Reset state with req held high.
    repeat (2) @(negedge clk);
    check("reset addr_ok", busA.addr_ok, 0);
    check("reset data_ok", busA.data_ok, 0);
    check("reset busy", busA.busy, 0);
    check("reset rdata", busA.rdata, 0);
    check("reset err", busA.err, 0);
    @(posedge clk); #1;
    rstA = 1'b1; rstB = 1'b1; busA.req = 1'b0;

    // Word write and read back.
    issueA("wr word 0x10", 1'b1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    issueA("rd word 0x10", 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte write over an existing word.
    issueA("wr base 0x10", 1'b1, 2'd2, 32'h10, 4'hF, 32'h11223344, 32'h0, 1'b0);
    issueA("wr byte 0x13", 1'b1, 2'd0, 32'h13, 4'b1000, 32'hAA000000, 32'h0, 1'b0);
    issueA("rd after byte", 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hAA223344, 1'b0);

    // Illegal and misaligned accesses.
    issueA("rd word misaligned", 1'b0, 2'd2, 32'h12, 4'h0, 32'h0, 32'h0, 1'b1);
    issueA("wr half misaligned", 1'b1, 2'd1, 32'h11, 4'b0110, 32'h00FFFF00, 32'h0, 1'b1);
    issueA("rd size3", 1'b0, 2'd3, 32'h10, 4'h0, 32'h0, 32'h0, 1'b1);
    issueA("rd unchanged", 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hAA223344, 1'b0);

    // Legal half write, then byte read at an odd address returns the full word.
    issueA("wr half 0x12", 1'b1, 2'd1, 32'h12, 4'b1100, 32'hBEEF0000, 32'h0, 1'b0);
    issueA("rd byte 0x13", 1'b0, 2'd0, 32'h13, 4'h0, 32'h0, 32'hBEEF3344, 1'b0);

    // Address wrap modulo depth.
    issueA("wr wrap 0x1000", 1'b1, 2'd2, 32'h1000, 4'hF, 32'h00001234, 32'h0, 1'b0);
    issueA("rd wrap 0x0", 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 32'h00001234, 1'b0);

    // Reset while a write is waiting: no response, no commit.
    @(posedge clk); #1;
    busA.req = 1'b1; busA.wr = 1'b1; busA.size = 2'd2;
    busA.addr = 32'h10; busA.wstrb = 4'hF; busA.wdata = 32'h55555555;
    @(negedge clk);
    check("abort wr accepted", busA.addr_ok, 1);
    @(posedge clk); #1;
    rstA = 1'b0;
    busA.wr = 1'b0; busA.wstrb = 4'h0; busA.wdata = 32'h0;
    @(negedge clk);
    check("abort busy in reset", busA.busy, 0);
    check("abort addr_ok in reset", busA.addr_ok, 0);
    repeat (2) @(negedge clk);
    check("abort data_ok in reset", busA.data_ok, 0);
    @(posedge clk); #1;
    rstA = 1'b1;
    @(negedge clk);
    check("addr_ok after release", busA.addr_ok, 1);
    if (busA.addr_ok) qA.push_back('{32'hBEEF3344, 1'b0, cyc + LAT_A});
    @(posedge clk); #1;
    busA.req = 1'b0;
    drainA("rd after abort");

    // LATENCY=1 instance with req held high: writes then reads back-to-back.
    @(posedge clk); #1;
    expRdB = 32'h0;
    busB.wr = 1'b1; busB.size = 2'd2; busB.addr = 32'h20;
    busB.wstrb = 4'hF; busB.wdata = 32'h0A0B0C0D; busB.req = 1'b1;
    n = 0;
    while (accB.size() < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("B write phase accepts", accB.size(), 3);
    busB.wr = 1'b0; busB.wdata = 32'h0; expRdB = 32'h0A0B0C0D;
    n = 0;
    while (accB.size() < 6 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    busB.req = 1'b0;
    check("B total accepts", accB.size(), 6);
    for (int i = 1; i < accB.size(); i++) begin
      check("B accept spacing", accB[i] - accB[i-1], 2);
    end
    n = 0;
    while (qB.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("B response timeout", qB.size(), 0);

    repeat (4) @(posedge clk);
    check("A queue empty at end", qA.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to data_ok; legal range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning log2 of word depth of internal memory.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  initiator request valid.
REQ-006 SHALL have port wr  input  1  1=write, 0=read.
REQ-007 SHALL have port size  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wstrb  input  4  byte-lane write enables.
REQ-010 SHALL have port wdata  input  32  lane-aligned write data.
REQ-011 SHALL have port addr_ok  output  1  request accepted this cycle.
REQ-012 SHALL have port data_ok  output  1  response valid, one-cycle pulse.
REQ-013 SHALL have port rdata  output  32  full read word, valid with data_ok.
REQ-014 SHALL have port err  output  1  misaligned/illegal request, valid with data_ok.
REQ-015 SHALL have port busy  output  1  transaction outstanding.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; at most one outstanding transaction.
REQ-017 SHALL drive addr_ok = req in IDLE, 0 in WAIT/RESP; acceptance = req & addr_ok at a rising edge (edge E0).
REQ-018 SHALL latch wr, size, addr, wstrb, wdata at E0; later input changes SHALL NOT affect the transaction.
REQ-019 SHALL transition IDLE->RESP at E0 when LATENCY=1, otherwise IDLE->WAIT with a down-counter loaded with LATENCY-2.
REQ-020 SHALL stay in WAIT while counter nonzero, decrement per cycle, and go WAIT->RESP when counter is 0.
REQ-021 SHALL assert data_ok only in RESP, for exactly one cycle, i.e. in the cycle following edge E(LATENCY-1); RESP->IDLE unconditionally.
REQ-022 SHALL NOT accept a new request in RESP; minimum request spacing is LATENCY+1 cycles.
REQ-023 SHALL assert busy in WAIT and RESP.
REQ-024 SHALL flag err when size=3, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
REQ-025 SHALL commit a write at the edge ending RESP, only to lanes with wstrb set, only when err=0; rdata SHALL be 0 for writes.
REQ-026 SHALL return on read the full memory word at index addr[ADDR_W+1:2] registered into rdata, held stable through RESP; rdata=0 when err=1.
REQ-027 SHALL ignore addr bits above ADDR_W+1 (address wraps modulo depth).
REQ-028 SHALL return, for a read following a write to the same word, the post-write contents.
REQ-029 SHALL drive rdata and err to 0 whenever data_ok=0.

Reset
REQ-030 SHALL, while rst=0, force state IDLE, counter 0, addr_ok=0, data_ok=0, busy=0, rdata=0, err=0.
REQ-031 SHALL abort any in-flight transaction on reset with no write committed and no data_ok issued.
REQ-032 SHALL NOT clear memory contents on reset.

Structure
REQ-033 SHALL place size encodings (SIZE_B, SIZE_H, SIZE_W) and FSM state encoding in a shared package.
REQ-034 SHALL instantiate one sub-module, be_ram: synchronous single-port RAM, 2^ADDR_W x 32, per-byte write enables, one-cycle read.

Verification
REQ-035 SHALL cover: LATENCY=2, write word 0xDEADBEEF to 0x10 wstrb=1111, then read 0x10 -> addr_ok same cycle as req, data_ok 2 cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-036 SHALL cover: byte write 0xAA at 0x13 wstrb=1000 over 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-037 SHALL cover: read size=2 at 0x12 -> data_ok with err=1, rdata=0, memory unchanged; half write at 0x11 -> err=1, no write.
REQ-038 SHALL cover: req held high continuously with LATENCY=1 -> accepts every 2nd cycle, data_ok one cycle after each acceptance, addr_ok never high while busy.
REQ-039 SHALL cover: rst=0 asserted in WAIT during a write of 0x55555555 -> no data_ok, prior word contents retained, addr_ok=req in first cycle after release.
REQ-040 SHALL cover: ADDR_W=10, write 0x1234 to 0x1000 then read 0x0000 -> rdata=0x00001234 (wrap).
